// File: rtl/fp_div_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fp_div_arbiter_pkg
// Shared definitions for the divider arbiter: operand width, a few IEEE-754
// single-precision constants used by the HSV datapath, and the tag record that
// follows each division through the divider latency.
// -----------------------------------------------------------------------------
package fp_div_arbiter_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_100  = 32'h42c8_0000;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    // Tag id is sized for the largest supported requester count (8).
    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            dz;
    } tag_t;

    // +0 and -0 both count as a zero denominator: ignore the sign bit.
    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        return (x[FP_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/fp_div_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_div_arbiter_if
// Bundles the requester handshake, the divider issue/return bus and the
// response strobe of the divider arbiter.
//   slave  : arbiter view (takes requests and divider results, drives grants,
//            divider operands and responses)
//   master : environment view (requesters + divider + response consumers)
// Requester i operands live at [i*DATA_W +: DATA_W] of req_num / req_den.
// -----------------------------------------------------------------------------
interface fp_div_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_num;
    logic [NUM_REQ*DATA_W-1:0] req_den;
    logic [NUM_REQ-1:0]        req_ready;

    logic [DATA_W-1:0]         div_num;
    logic [DATA_W-1:0]         div_den;
    logic                      div_valid_in;
    logic [DATA_W-1:0]         div_result;
    logic                      div_valid_out;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_dz;

    modport slave (
        input  req_valid, req_num, req_den, div_result, div_valid_out,
        output req_ready, div_num, div_den, div_valid_in,
               rsp_valid, rsp_data, rsp_dz
    );

    modport master (
        output req_valid, req_num, req_den, div_result, div_valid_out,
        input  req_ready, div_num, div_den, div_valid_in,
               rsp_valid, rsp_data, rsp_dz
    );
endinterface

// File: rtl/fp_div_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant among NUM_REQ requesters. The search starts at the pointer
// and wraps; the pointer moves just past the winner on every grant.
//   clk, rst  : clock, async active-low reset (pointer -> 0)
//   en        : 0 suppresses all grants (pointer holds)
//   req       : per-requester request
//   grant     : one-hot grant (combinational)
//   grant_idx : index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr;

    // Walk from the farthest candidate back to ptr so the last hit wins;
    // that is the first requester at or after ptr in wrap order.
    always_comb begin
        int               j;
        logic [PTR_W-1:0] jj;
        grant     = '0;
        grant_idx = '0;
        j         = 0;
        jj        = '0;
        if (en) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = int'(ptr) + k;
                if (j >= NUM_REQ) begin
                    j = j - NUM_REQ;
                end
                jj = PTR_W'(j);
                if (req[jj]) begin
                    grant     = '0;
                    grant[jj] = 1'b1;
                    grant_idx = jj;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fp_div_arbiter.sv
// -----------------------------------------------------------------------------
// fp_div_arbiter
// Shares one pipelined single-precision divider between NUM_REQ requesters.
// At most one division is issued per cycle; each issued op carries a tag
// (owner id, zero-denominator flag) down a pipeline matched to the divider
// latency so the quotient can be routed back to its owner. Operands and
// results pass through untouched.
//   clk, rst  : clock, async active-low reset
//   en        : 1 = grants allowed; 0 = no new grants, in-flight ops drain
//   bus       : requester handshake, divider issue/return, response strobe
//   busy      : any op in the issue register or tag pipeline
//   err_sync  : sticky, set when divider result strobe and tag disagree
// -----------------------------------------------------------------------------
module fp_div_arbiter
    import fp_div_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = 4,
    parameter int DATA_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    fp_div_arbiter_if.slave    bus,
    output logic               busy,
    output logic               err_sync
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               accept;
    logic [DATA_W-1:0]  sel_num;
    logic [DATA_W-1:0]  sel_den;
    tag_t               issue_tag;
    tag_t               tail;
    logic [NUM_REQ-1:0] rsp_onehot;

    // Entry 0 is loaded together with div_valid_in (the issue register);
    // entry DIV_LATENCY lines up with div_valid_out.
    tag_t tag_pipe [DIV_LATENCY+1];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = grant;
    assign accept        = |grant;

    always_comb begin
        sel_num = '0;
        sel_den = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_num = bus.req_num[k*DATA_W +: DATA_W];
                sel_den = bus.req_den[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = accept;
        issue_tag.id    = ID_W'(grant_idx);
        issue_tag.dz    = accept & fp_is_zero(sel_den);
    end

    // Issue register to the divider; operands hold while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.div_valid_in <= 1'b0;
            bus.div_num      <= '0;
            bus.div_den      <= '0;
        end else begin
            bus.div_valid_in <= accept;
            if (accept) begin
                bus.div_num <= sel_num;
                bus.div_den <= sel_den;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= DIV_LATENCY; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int k = 1; k <= DIV_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign tail = tag_pipe[DIV_LATENCY];

    always_comb begin
        rsp_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_onehot[k] = (tail.id == ID_W'(k));
        end
    end

    // A result only counts when tag and strobe agree; any disagreement is
    // recorded and produces no response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_dz    <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            if (tail.valid && bus.div_valid_out) begin
                bus.rsp_valid <= rsp_onehot;
                bus.rsp_data  <= bus.div_result;
                bus.rsp_dz    <= tail.dz;
            end
            if (tail.valid ^ bus.div_valid_out) begin
                err_sync <= 1'b1;
            end
        end
    end

    always_comb begin
        busy = bus.div_valid_in;
        for (int k = 0; k <= DIV_LATENCY; k++) begin
            busy = busy | tag_pipe[k].valid;
        end
    end

endmodule
